// File: rtl/i8008_bus_responder.sv
// Bus-side peer of i8008_core: decodes T-state/Sync/D_out into memory and I/O
// transactions, returns read data or interrupt jam opcodes, and stalls via READY.
module i8008_bus_responder #(
    parameter int unsigned IO_IN_PORTS  = 8,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  core_d_out,
    input  logic [2:0]  core_state,
    input  logic        core_sync,
    output logic [7:0]  core_d_in,
    output logic        core_ready,
    output logic        core_intr,
    input  logic        intr_req,
    input  logic [7:0]  irq_opcode,
    output logic [13:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  io_port,
    output logic        io_rd,
    output logic        io_wr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    output logic        bus_err
);

    localparam logic [2:0] ST_T1  = 3'b010;
    localparam logic [2:0] ST_T1I = 3'b110;
    localparam logic [2:0] ST_T2  = 3'b100;
    localparam logic [2:0] ST_T3  = 3'b001;

    localparam logic [1:0] CT_PCI = 2'b00;
    localparam logic [1:0] CT_PCR = 2'b10;
    localparam logic [1:0] CT_PCC = 2'b01;
    localparam logic [1:0] CT_PCW = 2'b11;

    localparam int unsigned TW       = 8;
    localparam logic [TW-1:0] TMO_LAST = TW'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, IO} state_t;

    state_t        state;
    logic [7:0]    addr_lo;
    logic [5:0]    addr_hi;
    logic [1:0]    ctype;
    logic          int_cyc;
    logic          wr_armed;
    logic          t2_pend;
    logic          intr_armed;
    logic [TW-1:0] timer;

    logic       t2_s_c, t3_s_c, t1i_s_c;
    logic       timeout_c, done_c, dsp_go_c;
    logic [1:0] dsp_ctype_c;
    logic [4:0] dsp_port_c;
    logic [5:0] dsp_hi_c;

    // A T2 is dispatched either live (from D_out) or deferred behind a posted write (from latches).
    always_comb begin
        t2_s_c      = core_sync && (core_state == ST_T2);
        t3_s_c      = core_sync && (core_state == ST_T3);
        t1i_s_c     = core_sync && (core_state == ST_T1I);
        timeout_c   = (mem_rd || mem_wr) && !mem_ack && (timer == TMO_LAST);
        done_c      = (state == WR_REQ) && (mem_ack || timeout_c);
        dsp_go_c    = (t2_s_c && ((state == IDLE) || done_c)) || (t2_pend && done_c);
        dsp_ctype_c = core_d_out[7:6];
        dsp_port_c  = core_d_out[5:1];
        dsp_hi_c    = core_d_out[5:0];
        if (t2_pend) begin
            dsp_ctype_c = ctype;
            dsp_port_c  = io_port;
            dsp_hi_c    = addr_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_lo    <= 8'h00;
            addr_hi    <= 6'h00;
            ctype      <= CT_PCI;
            int_cyc    <= 1'b0;
            wr_armed   <= 1'b0;
            t2_pend    <= 1'b0;
            intr_armed <= 1'b1;
            timer      <= '0;
            core_d_in  <= 8'h00;
            core_ready <= 1'b1;
            core_intr  <= 1'b0;
            mem_addr   <= 14'h0000;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= 8'h00;
            io_port    <= 5'h00;
            io_rd      <= 1'b0;
            io_wr      <= 1'b0;
            io_wdata   <= 8'h00;
            bus_err    <= 1'b0;
        end else begin
            if (core_sync) begin
                case (core_state)
                    ST_T1: begin
                        addr_lo  <= core_d_out;
                        int_cyc  <= 1'b0;
                        wr_armed <= 1'b0;
                    end
                    ST_T1I: begin
                        addr_lo  <= core_d_out;
                        int_cyc  <= 1'b1;
                        wr_armed <= 1'b0;
                    end
                    ST_T2: begin
                        addr_hi <= core_d_out[5:0];
                        ctype   <= core_d_out[7:6];
                        io_port <= core_d_out[5:1];
                    end
                    default: ;
                endcase
            end

            // Level request re-arms only once it has been seen low.
            if (!intr_req) intr_armed <= 1'b1;
            if (t1i_s_c) begin
                core_intr <= 1'b0;
            end else if (intr_req && intr_armed) begin
                core_intr  <= 1'b1;
                intr_armed <= 1'b0;
            end

            io_rd <= 1'b0;
            io_wr <= 1'b0;

            case (state)
                IDLE: begin
                    if (t3_s_c && wr_armed) begin
                        mem_wdata <= core_d_out;
                        mem_addr  <= {addr_hi, addr_lo};
                        mem_wr    <= 1'b1;
                        timer     <= '0;
                        wr_armed  <= 1'b0;
                        state     <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    if (mem_ack) begin
                        core_d_in  <= mem_rdata;
                        mem_rd     <= 1'b0;
                        core_ready <= 1'b1;
                        state      <= IDLE;
                    end else if (timeout_c) begin
                        core_d_in  <= 8'hFF;
                        mem_rd     <= 1'b0;
                        core_ready <= 1'b1;
                        bus_err    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WR_REQ: begin
                    if (done_c) begin
                        mem_wr     <= 1'b0;
                        core_ready <= 1'b1;
                        state      <= IDLE;
                        if (timeout_c) bus_err <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                        if (t2_s_c) begin
                            t2_pend    <= 1'b1;
                            core_ready <= 1'b0;
                        end
                    end
                end
                IO: begin
                    if (io_rd) core_d_in <= io_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Placed last so it overrides the write-completion return to IDLE.
            if (dsp_go_c) begin
                t2_pend    <= 1'b0;
                core_ready <= 1'b1;
                state      <= IDLE;
                case (dsp_ctype_c)
                    CT_PCI, CT_PCR: begin
                        if (dsp_ctype_c == CT_PCI && int_cyc) begin
                            core_d_in <= irq_opcode;
                        end else begin
                            mem_addr   <= {dsp_hi_c, addr_lo};
                            mem_rd     <= 1'b1;
                            core_ready <= 1'b0;
                            timer      <= '0;
                            state      <= RD_REQ;
                        end
                    end
                    CT_PCW: wr_armed <= 1'b1;
                    CT_PCC: begin
                        io_wdata <= addr_lo;
                        if (32'(dsp_port_c) < IO_IN_PORTS) io_rd <= 1'b1;
                        else                               io_wr <= 1'b1;
                        state <= IO;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i8008_bus_responder.sv
// Directed bench for i8008_bus_responder: fetch, posted write, I/O, interrupt,
// timeout and mid-transaction reset scenarios with hand-computed expectations.
module tb_i8008_bus_responder;

    localparam logic [2:0] S_T1   = 3'b010;
    localparam logic [2:0] S_T1I  = 3'b110;
    localparam logic [2:0] S_T2   = 3'b100;
    localparam logic [2:0] S_WAIT = 3'b000;
    localparam logic [2:0] S_T3   = 3'b001;
    localparam logic [2:0] S_STOP = 3'b011;
    localparam logic [2:0] S_T4   = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  core_d_out;
    logic [2:0]  core_state;
    logic        core_sync;
    logic [7:0]  core_d_in;
    logic        core_ready;
    logic        core_intr;
    logic        intr_req;
    logic [7:0]  irq_opcode;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [4:0]  io_port;
    logic        io_rd;
    logic        io_wr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i8008_bus_responder dut (
        .clk(clk), .rst(rst),
        .core_d_out(core_d_out), .core_state(core_state), .core_sync(core_sync),
        .core_d_in(core_d_in), .core_ready(core_ready), .core_intr(core_intr),
        .intr_req(intr_req), .irq_opcode(irq_opcode),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_port(io_port), .io_rd(io_rd), .io_wr(io_wr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .bus_err(bus_err)
    );

    // Drive one bus sample at the falling edge; return 1 ns after the rising edge.
    task automatic step(input logic [2:0] st, input logic [7:0] d, input logic sy);
        @(negedge clk);
        core_state = st;
        core_d_out = d;
        core_sync  = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(S_WAIT, 8'h00, 1'b0);
        step(S_WAIT, 8'h00, 1'b0);
        rst = 1'b0;
        checks++; if (core_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", core_ready); end
        checks++; if (core_d_in !== 8'h00) begin errors++; $display("FAIL reset_d_in got %h exp 00", core_d_in); end
        checks++; if ({mem_rd, mem_wr, io_rd, io_wr, core_intr, bus_err} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes got %b exp 000000", {mem_rd, mem_wr, io_rd, io_wr, core_intr, bus_err}); end
        checks++; if (mem_addr !== 14'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
    endtask

    task automatic test_fetch;
        int low;
        step(S_T1, 8'h34, 1'b1);
        step(S_T2, 8'h12, 1'b1);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 14'h1234) begin
            errors++; $display("FAIL fetch_req got rd=%b addr=%h exp rd=1 addr=1234", mem_rd, mem_addr); end
        low = 0;
        for (int i = 1; i <= 10; i++) begin
            if (core_ready === 1'b0) low++;
            mem_ack   = (i == 4);
            mem_rdata = 8'hC0;
            step(S_WAIT, 8'h00, 1'b1);
        end
        mem_ack = 1'b0;
        checks++; if (low != 4) begin errors++; $display("FAIL fetch_ready_low got %0d exp 4", low); end
        checks++; if (core_d_in !== 8'hC0 || mem_rd !== 1'b0 || core_ready !== 1'b1) begin
            errors++; $display("FAIL fetch_data got d=%h rd=%b rdy=%b exp d=c0 rd=0 rdy=1", core_d_in, mem_rd, core_ready); end
    endtask

    task automatic test_write_back_to_back;
        step(S_T1, 8'h77, 1'b1);
        step(S_T2, 8'hC5, 1'b1);
        checks++; if (core_ready !== 1'b1 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL wr_t2 got rdy=%b wr=%b exp rdy=1 wr=0", core_ready, mem_wr); end
        step(S_T3, 8'hAA, 1'b1);
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 14'h0577 || mem_wdata !== 8'hAA) begin
            errors++; $display("FAIL wr_issue got wr=%b addr=%h data=%h exp wr=1 addr=0577 data=aa", mem_wr, mem_addr, mem_wdata); end
        step(S_T1, 8'h10, 1'b1);
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 14'h0577 || core_ready !== 1'b1) begin
            errors++; $display("FAIL wr_posted got wr=%b addr=%h rdy=%b exp wr=1 addr=0577 rdy=1", mem_wr, mem_addr, core_ready); end
        step(S_T2, 8'h00, 1'b1);
        step(S_WAIT, 8'h00, 1'b1);
        checks++; if (core_ready !== 1'b0 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL wr_stall got rdy=%b rd=%b exp rdy=0 rd=0", core_ready, mem_rd); end
        mem_ack = 1'b1;
        step(S_WAIT, 8'h00, 1'b1);
        mem_ack = 1'b0;
        checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || core_ready !== 1'b0 || mem_addr !== 14'h0010) begin
            errors++; $display("FAIL wr_then_rd got wr=%b rd=%b rdy=%b addr=%h exp wr=0 rd=1 rdy=0 addr=0010",
                               mem_wr, mem_rd, core_ready, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        step(S_WAIT, 8'h00, 1'b1);
        mem_ack = 1'b0;
        checks++; if (core_d_in !== 8'h3C || core_ready !== 1'b1) begin
            errors++; $display("FAIL wr_rd_data got d=%h rdy=%b exp d=3c rdy=1", core_d_in, core_ready); end
    endtask

    task automatic test_io;
        step(S_T1, 8'h5A, 1'b1);
        step(S_T2, 8'h51, 1'b1);
        checks++; if (io_wr !== 1'b1 || io_rd !== 1'b0 || io_port !== 5'd8 || io_wdata !== 8'h5A || core_ready !== 1'b1) begin
            errors++; $display("FAIL io_out got wr=%b rd=%b port=%0d wdata=%h rdy=%b exp wr=1 rd=0 port=8 wdata=5a rdy=1",
                               io_wr, io_rd, io_port, io_wdata, core_ready); end
        step(S_T3, 8'h00, 1'b1);
        checks++; if (io_wr !== 1'b0 || core_d_in !== 8'h3C) begin
            errors++; $display("FAIL io_out_end got wr=%b d=%h exp wr=0 d=3c", io_wr, core_d_in); end
        step(S_T1, 8'h99, 1'b1);
        io_rdata = 8'h6B;
        step(S_T2, 8'h46, 1'b1);
        checks++; if (io_rd !== 1'b1 || io_wr !== 1'b0 || io_port !== 5'd3 || io_wdata !== 8'h99 || core_d_in !== 8'h3C) begin
            errors++; $display("FAIL io_in got rd=%b wr=%b port=%0d wdata=%h d=%h exp rd=1 wr=0 port=3 wdata=99 d=3c",
                               io_rd, io_wr, io_port, io_wdata, core_d_in); end
        step(S_T3, 8'h00, 1'b1);
        checks++; if (io_rd !== 1'b0 || core_d_in !== 8'h6B) begin
            errors++; $display("FAIL io_in_data got rd=%b d=%h exp rd=0 d=6b", io_rd, core_d_in); end
    endtask

    task automatic test_interrupt;
        irq_opcode = 8'hD7;
        intr_req   = 1'b1;
        step(S_STOP, 8'h00, 1'b1);
        checks++; if (core_intr !== 1'b1) begin errors++; $display("FAIL intr_set got %b exp 1", core_intr); end
        step(S_T1I, 8'h00, 1'b1);
        checks++; if (core_intr !== 1'b0) begin errors++; $display("FAIL intr_clear got %b exp 0", core_intr); end
        step(S_T2, 8'h00, 1'b1);
        checks++; if (core_d_in !== 8'hD7 || mem_rd !== 1'b0 || core_ready !== 1'b1 || core_intr !== 1'b0) begin
            errors++; $display("FAIL intr_jam got d=%h rd=%b rdy=%b intr=%b exp d=d7 rd=0 rdy=1 intr=0",
                               core_d_in, mem_rd, core_ready, core_intr); end
        intr_req = 1'b0;
        step(S_T3, 8'h00, 1'b1);
        intr_req = 1'b1;
        step(S_T4, 8'h00, 1'b1);
        checks++; if (core_intr !== 1'b1) begin errors++; $display("FAIL intr_rearm got %b exp 1", core_intr); end
        intr_req = 1'b0;
        step(S_T1I, 8'h00, 1'b1);
        checks++; if (core_intr !== 1'b0) begin errors++; $display("FAIL intr_clear2 got %b exp 0", core_intr); end
    endtask

    task automatic test_timeout;
        int cnt;
        step(S_T1, 8'h01, 1'b1);
        step(S_T2, 8'h80, 1'b1);
        cnt = 0;
        for (int i = 0; i < 400 && mem_rd === 1'b1; i++) begin
            cnt++;
            step(S_WAIT, 8'h00, 1'b1);
        end
        checks++; if (cnt != 255) begin errors++; $display("FAIL tmo_cycles got %0d exp 255", cnt); end
        checks++; if (bus_err !== 1'b1 || core_d_in !== 8'hFF || core_ready !== 1'b1 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL tmo_result got err=%b d=%h rdy=%b rd=%b exp err=1 d=ff rdy=1 rd=0",
                               bus_err, core_d_in, core_ready, mem_rd); end
        step(S_T3, 8'h00, 1'b1);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", bus_err); end
    endtask

    task automatic test_reset_mid;
        step(S_T1, 8'h22, 1'b1);
        step(S_T2, 8'h33, 1'b1);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 14'h3322) begin
            errors++; $display("FAIL rstmid_req got rd=%b addr=%h exp rd=1 addr=3322", mem_rd, mem_addr); end
        rst = 1'b1;
        step(S_WAIT, 8'h00, 1'b1);
        rst = 1'b0;
        checks++; if (mem_rd !== 1'b0 || core_ready !== 1'b1 || bus_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_abort got rd=%b rdy=%b err=%b exp rd=0 rdy=1 err=0", mem_rd, core_ready, bus_err); end
        mem_ack = 1'b1; mem_rdata = 8'h55;
        step(S_WAIT, 8'h00, 1'b1);
        mem_ack = 1'b0;
        step(S_WAIT, 8'h00, 1'b1);
        checks++; if (core_d_in !== 8'h00 || core_ready !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL rstmid_late_ack got d=%h rdy=%b rd=%b wr=%b exp d=00 rdy=1 rd=0 wr=0",
                               core_d_in, core_ready, mem_rd, mem_wr); end
    endtask

    initial begin
        rst        = 1'b1;
        core_d_out = 8'h00;
        core_state = S_WAIT;
        core_sync  = 1'b0;
        intr_req   = 1'b0;
        irq_opcode = 8'h00;
        mem_rdata  = 8'h00;
        mem_ack    = 1'b0;
        io_rdata   = 8'h00;
        test_reset;
        test_fetch;
        test_write_back_to_back;
        test_io;
        test_interrupt;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
